// File: rtl/imaging_pkg.sv
// Shared pixel/counter types for the capture-to-convolution imaging path.
package imaging_pkg;
    localparam int PIX_W = 12;
    localparam int CNT_W = 11;
    localparam int SUM_W = PIX_W + 2;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Mean of four samples, truncated; the 14-bit sum cannot overflow.
    function automatic pix_t quad_mean(input pix_t a, input pix_t b,
                                       input pix_t c, input pix_t d);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(c) + SUM_W'(d);
        return sum[SUM_W-1:2];
    endfunction
endpackage

// File: rtl/gray_line_buffer.sv
// Clock-enabled shift-register line delay with one tap at full depth.
module gray_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             clken,
    input  logic [WIDTH-1:0] shiftin,
    output logic [WIDTH-1:0] tap
);
    // Contents are deliberately unreset; they are overwritten by the first row.
    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (clken) sr <= {sr[DEPTH-2:0], shiftin};
    end

    assign tap = sr[DEPTH-1];
endmodule

// File: rtl/raw_to_gray.sv
// Bayer RAW to half-resolution grayscale: each 2x2 quad becomes its mean.
module raw_to_gray import imaging_pkg::*; #(
    parameter int LINE_WIDTH = 1280,
    parameter int CNT_W      = imaging_pkg::CNT_W
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [11:0]      iDATA,
    input  logic             iDVAL,
    input  logic [CNT_W-1:0] iX_Cont,
    input  logic [CNT_W-1:0] iY_Cont,
    output logic [11:0]      oGray,
    output logic             oDVAL
);
    generate
        if ((LINE_WIDTH % 2) != 0 || LINE_WIDTH < 2) begin : g_bad_width
            $error("raw_to_gray: LINE_WIDTH must be even and at least 2");
        end
    endgenerate

    pix_t tap;
    pix_t d_cur;
    pix_t d_tap;
    logic emit;
    logic unused_cnt_msbs;

    gray_line_buffer #(
        .DEPTH (LINE_WIDTH),
        .WIDTH (PIX_W)
    ) u_line (
        .clk     (iCLK),
        .clken   (iDVAL),
        .shiftin (iDATA),
        .tap     (tap)
    );

    // Only parity matters, so counter wrap at frame start needs no handling.
    assign emit            = iDVAL & iX_Cont[0] & iY_Cont[0];
    assign unused_cnt_msbs = ^{iX_Cont[CNT_W-1:1], iY_Cont[CNT_W-1:1]};

    // Quad at odd/odd: R=d_tap, G1=tap, G2=d_cur, B=iDATA.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            d_cur <= '0;
            d_tap <= '0;
            oGray <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= emit;
            if (iDVAL) begin
                d_cur <= iDATA;
                d_tap <= tap;
            end
            if (emit) oGray <= quad_mean(d_tap, tap, d_cur, iDATA);
        end
    end
endmodule

// File: doc/raw_to_gray.md
Name: raw_to_gray

Overview:
- Upstream neighbour of the 3x3 convolution stage. Consumes the 12-bit Bayer RAW pixel stream from the capture block, together with its column/row counters.
- Collapses each 2x2 Bayer quad (R, G1, G2, B) into one 12-bit grayscale pixel equal to the mean of the four samples.
- Output is a qualified pixel stream (oGray/oDVAL) at half resolution in each dimension. It feeds the convolution stage's iDATA/iDVAL directly.

Parameters:
- LINE_WIDTH, 1280, number of valid RAW pixels per sensor row. Sets the line-buffer depth.
- CNT_W, 11, width of the column/row counter inputs.

Ports:
- iCLK  input  1  pixel clock
- iRST  input  1  asynchronous active-low reset
- iDATA  input  12  RAW Bayer sample, unsigned
- iDVAL  input  1  iDATA valid; all state advances only when high
- iX_Cont  input  CNT_W  column index of iDATA (0..LINE_WIDTH-1)
- iY_Cont  input  CNT_W  row index of iDATA
- oGray  output  12  grayscale pixel, unsigned
- oDVAL  output  1  oGray valid, single-cycle pulse per quad

Behaviour:
- Clocking and reset: one clock, iCLK. Reset iRST is asynchronous and active-low.
- Reset values: oGray=0, oDVAL=0, column-delay registers=0. Line-buffer contents are not reset; they are don't-care until one full row has been shifted in.
- Line buffer:
  - Shift depth LINE_WIDTH, clock-enabled by iDVAL.
  - Shift input is iDATA. Tap output is the sample from the same column, previous row.
- Column delay: on each iDVAL, register iDATA→dCur and tap→dTap. These hold the left-hand column of the quad.
- Quad assembly, at an accepted pixel with iX_Cont[0]=1 and iY_Cont[0]=1:
  - R = dTap, G1 = tap, G2 = dCur, B = iDATA.
- Arithmetic:
  - sum = R+G1+G2+B, 14 bits unsigned, no overflow possible.
  - oGray = sum[13:2] (truncating divide by 4, no rounding).
- Emit: on the iCLK edge where iDVAL=1 and both LSBs=1, register oGray and set oDVAL=1.
  - Latency: one cycle from acceptance of the B sample.
  - On all other cycles oDVAL=0 and oGray holds its last value.
- iDVAL low:
  - Line buffer, delay registers and oGray frozen; oDVAL=0.
  - Gaps of any length, including mid-quad, must not change results.
- Row 0 / even rows: never emit.
  - First frame after reset: the row-1 result uses genuine row-0 data, since row 0 fills the buffer.
- Odd rows, even columns: never emit.
- Throughput: exactly (LINE_WIDTH/2) outputs per odd row. A frame of LINE_WIDTH×H yields (LINE_WIDTH/2)×(H/2) pulses.
- Line length: upstream guarantees exactly LINE_WIDTH valid pixels per row. Behaviour with other lengths is unspecified, with no assertion required.
- Wrap-around: counter restart at frame start needs no special handling. Parity alone decides emission.
- Reset mid-frame: outputs clear immediately (asynchronous). After release, the first emission occurs at the next odd/odd pixel. Data from the stale buffer in that first row is permitted to be wrong; subsequent rows must be exact.
- LINE_WIDTH must be even. Enforce with an elaboration-time check.

Decomposition:
- Shared package (imaging_pkg):
  - PIX_W=12
  - CNT_W=11
  - typedef pix_t (logic [11:0])
  - typedef cnt_t
- Sub-module gray_line_buffer:
  - Parameterised depth/width shift register with clken, shiftin and a single tap output.
  - Replaces the vendor megafunction so the block simulates standalone.
- Top holds the delay registers, sum, emit logic and output registers.

Test Plan:
- Uniform frame: LINE_WIDTH=8, 4 rows, all samples 12'h100, iDVAL constantly high → 8 oDVAL pulses, each oGray=12'h100, each one cycle after an odd/odd pixel.
- Distinct quad: row0 cols0/1 = 1, 2 and row1 cols0/1 = 3, 4 (sum 10) → oGray=2. Same quad with 4095 ×4 → oGray=4095 (no overflow).
- Bubbles: same frame with iDVAL deasserted for 3 cycles between every pixel, including between G2 and B → identical oGray sequence and pulse count; oDVAL never high while iDVAL low.
- Parity gating: random data, 1280×960 frame → exactly 307200 pulses. Every value matches a reference model (mean of quad, truncated); no pulse on any even row or even column.
- Reset mid-frame: assert iRST during row 3, col 5 → oDVAL/oGray=0 in the same cycle, without waiting for a clock. Restart frame → results correct from the second odd row onward.
- Truncation: quad 1, 1, 1, 0 (sum 3) → oGray=0. Quad 2, 2, 2, 1 (sum 7) → oGray=1.
